// File: rtl/snake_pkg.sv
// Shared widths, limits and FSM encoding for the snake body sequencer.
package snake_pkg;

  localparam int COORD_W  = 7;
  localparam int IDX_W    = 4;
  localparam int MAX_LEN  = 15;
  localparam int INIT_LEN = 3;
  localparam int SEG_W    = 2 * COORD_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_READ  = 3'd2,
    ST_LATCH = 3'd3,
    ST_WRITE = 3'd4,
    ST_HEAD  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Length after a step: grow adds one segment unless the body is already full.
  function automatic logic [IDX_W-1:0] next_len(input logic [IDX_W-1:0] len,
                                                input logic grow);
    if (grow && (len != IDX_W'(MAX_LEN)))
      return len + 1'b1;
    else
      return len;
  endfunction

endpackage

// File: rtl/snake_seg_ram.sv
// Single-port 16x14 segment store with registered read; contents are never reset.
module snake_seg_ram
  import snake_pkg::*;
(
  input  logic             clock_25,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [SEG_W-1:0] wdata,
  output logic [SEG_W-1:0] q
);

  logic [SEG_W-1:0] mem [0:(2**IDX_W)-1];

  always_ff @(posedge clock_25) begin
    if (we)
      mem[addr] <= wdata;
    q <= mem[addr];
  end

endmodule

// File: rtl/snake_body_sequencer.sv
// Shifts the snake body in the shared segment RAM during blanking and flags self-collision.
module snake_body_sequencer
  import snake_pkg::*;
#(
  parameter int INIT_X = 20,
  parameter int INIT_Y = 15
) (
  input  logic               clock_25,
  input  logic               reset,
  input  logic               start,
  input  logic               game_tik,
  input  logic               grow,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic               display_area,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic [IDX_W-1:0]   snake_length,
  output logic               busy,
  output logic               done,
  output logic               self_collision,
  output logic               tik_overrun
);

  generate
    if (INIT_X < 2) begin : g_bad_init_x
      $error("snake_body_sequencer: INIT_X must be at least 2");
    end
  endgenerate

  localparam logic [COORD_W-1:0] INIT_XC = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] INIT_YC = COORD_W'(INIT_Y);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   len_new;
  logic [1:0]         init_cnt;
  logic [SEG_W-1:0]   hold;
  logic [SEG_W-1:0]   head_reg;
  logic               pend;
  logic [SEG_W-1:0]   pend_head;
  logic               pend_grow;
  logic               coll;

  logic               grant;
  logic               seq_we;
  logic [IDX_W-1:0]   seq_addr;
  logic [SEG_W-1:0]   seq_wdata;
  logic               ram_we;
  logic [IDX_W-1:0]   ram_addr;
  logic [SEG_W-1:0]   ram_q;

  logic               use_pend;
  logic               launch_grow;
  logic [SEG_W-1:0]   launch_head;
  logic [IDX_W-1:0]   launch_len;

  // The renderer owns the port whenever the beam is in the visible area.
  assign grant    = !display_area;
  assign ram_addr = display_area ? rd_idx : seq_addr;
  assign ram_we   = grant & seq_we;
  assign rd_x     = ram_q[SEG_W-1:COORD_W];
  assign rd_y     = ram_q[COORD_W-1:0];

  always_comb begin
    seq_we    = 1'b0;
    seq_addr  = '0;
    seq_wdata = '0;
    case (state)
      ST_INIT: begin
        seq_we    = 1'b1;
        seq_addr  = IDX_W'(init_cnt);
        seq_wdata = {INIT_XC - COORD_W'(init_cnt), INIT_YC};
      end
      ST_READ:  seq_addr = idx - 1'b1;
      ST_WRITE: begin
        seq_we    = 1'b1;
        seq_addr  = idx;
        seq_wdata = hold;
      end
      ST_HEAD: begin
        seq_we    = 1'b1;
        seq_wdata = head_reg;
      end
      default: ;
    endcase
  end

  // A step launched from DONE uses the queued tik; from IDLE it uses the live inputs.
  assign use_pend    = (state == ST_DONE) && pend;
  assign launch_grow = use_pend ? pend_grow : grow;
  assign launch_head = use_pend ? pend_head : {head_x, head_y};
  assign launch_len  = next_len(snake_length, launch_grow);

  snake_seg_ram u_ram (
    .clock_25 (clock_25),
    .we       (ram_we),
    .addr     (ram_addr),
    .wdata    (seq_wdata),
    .q        (ram_q)
  );

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      len_new        <= '0;
      init_cnt       <= '0;
      hold           <= '0;
      head_reg       <= '0;
      pend           <= 1'b0;
      pend_head      <= '0;
      pend_grow      <= 1'b0;
      coll           <= 1'b0;
      snake_length   <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      self_collision <= 1'b0;
      tik_overrun    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state       <= ST_INIT;
        busy        <= 1'b1;
        init_cnt    <= '0;
        pend        <= 1'b0;
        tik_overrun <= 1'b0;
        coll        <= 1'b0;
      end else begin
        // One tik may queue behind a running step; a second one is lost.
        if (game_tik && (state != ST_IDLE) && (state != ST_DONE)) begin
          if (!pend) begin
            pend      <= 1'b1;
            pend_head <= {head_x, head_y};
            pend_grow <= grow;
          end else begin
            tik_overrun <= 1'b1;
          end
        end
        case (state)
          ST_IDLE: begin
            if (game_tik && (snake_length != '0)) begin
              head_reg <= launch_head;
              len_new  <= launch_len;
              idx      <= launch_len - 1'b1;
              busy     <= 1'b1;
              state    <= (launch_len == IDX_W'(1)) ? ST_HEAD : ST_READ;
            end
          end
          ST_INIT: begin
            if (grant) begin
              init_cnt <= init_cnt + 1'b1;
              if (init_cnt == 2'd2) begin
                snake_length   <= IDX_W'(INIT_LEN);
                self_collision <= 1'b0;
                coll           <= 1'b0;
                done           <= 1'b1;
                state          <= ST_DONE;
              end
            end
          end
          ST_READ: begin
            if (grant)
              state <= ST_LATCH;
          end
          ST_LATCH: begin
            hold <= ram_q;
            if (ram_q == head_reg)
              coll <= 1'b1;
            state <= ST_WRITE;
          end
          ST_WRITE: begin
            if (grant) begin
              idx   <= idx - 1'b1;
              state <= (idx == IDX_W'(1)) ? ST_HEAD : ST_READ;
            end
          end
          ST_HEAD: begin
            if (grant) begin
              snake_length   <= len_new;
              self_collision <= coll;
              coll           <= 1'b0;
              done           <= 1'b1;
              state          <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (pend || game_tik) begin
              head_reg <= launch_head;
              len_new  <= launch_len;
              idx      <= launch_len - 1'b1;
              pend     <= 1'b0;
              if (pend && game_tik)
                tik_overrun <= 1'b1;
              state <= (launch_len == IDX_W'(1)) ? ST_HEAD : ST_READ;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/snake_body_sequencer.md
Name: snake_body_sequencer

Overview:
- Owns the snake body segment store: a single-port 16x14-bit RAM holding {x,y} per segment, with index 0 as the head.
- On every game_tik it shifts the body one step, inserts the new head, optionally grows, and checks for self-collision.
- It shares the RAM port with the VGA renderer. The renderer has priority while display_area is high; the update runs in blanking.
- It sits between the game FSM (start, grow, head position) and the pixel generator (rd_idx/rd_x/rd_y).

Parameters:
- COORD_W, 7, width of one x or y coordinate.
- IDX_W, 4, segment index width.
- MAX_LEN, 15, maximum snake_length.
- INIT_X, 20, head x after start.
- INIT_Y, 15, head y after start.

Ports:
- clock_25  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse: (re)initialise the body.
- game_tik  in  1  1-cycle pulse: perform one body step.
- grow  in  1  sampled with game_tik: fruit eaten this step.
- head_x  in  7  new head x, sampled with game_tik.
- head_y  in  7  new head y, sampled with game_tik.
- display_area  in  1  high = renderer owns the RAM port.
- rd_idx  in  4  renderer read index.
- rd_x  out  7  renderer read data x, 1-cycle latency.
- rd_y  out  7  renderer read data y, 1-cycle latency.
- snake_length  out  4  current number of segments.
- busy  out  1  FSM not in IDLE.
- done  out  1  1-cycle pulse when a step or init completes.
- self_collision  out  1  new head matched a retained segment; updated with done.
- tik_overrun  out  1  sticky: a game_tik was dropped.

Behaviour:
- Reset (async, reset==0):
  - FSM goes to IDLE.
  - snake_length, busy, done, self_collision, tik_overrun, pending and all hold registers go to 0.
  - RAM contents are not reset.
- Port grant:
  - When display_area==1, the RAM address is rd_idx with no write.
  - rd_x/rd_y present the data one cycle after the address cycle.
  - Sequencer states that need the port (READ, WRITE, HEAD, INIT) advance only when display_area==0; otherwise they hold with no side effects.
- FSM states: IDLE, INIT, READ, LATCH, WRITE, HEAD, DONE.
- IDLE:
  - start goes to INIT. start has priority over game_tik.
  - game_tik with snake_length!=0 latches head_x, head_y and grow.
  - It computes L_new = min(snake_length + grow, MAX_LEN) and i = L_new-1.
  - If L_new==1 it goes to HEAD, otherwise to READ.
  - game_tik with snake_length==0 is ignored.
- INIT:
  - Writes seg0=(INIT_X,INIT_Y), seg1=(INIT_X-1,INIT_Y), seg2=(INIT_X-2,INIT_Y), one entry per granted cycle.
  - Then sets snake_length=3, clears self_collision and goes to DONE.
- READ: issues a read of seg[i-1], then goes to LATCH.
- LATCH:
  - Captures RAM q into the hold register; no grant is needed.
  - Compares hold against the latched head; on a match it sets the internal collision flag.
  - Goes to WRITE.
- WRITE:
  - Writes hold to seg[i] and decrements i.
  - If i becomes 0 it goes to HEAD, otherwise to READ.
- HEAD:
  - Writes the latched head to seg0.
  - Updates snake_length to L_new and goes to DONE.
- DONE:
  - done=1 for one cycle.
  - self_collision is set to the collision flag (clear the flag).
  - If pending is set, clear it and start a new step using the latched pending inputs; otherwise go to IDLE.
- Latency with display_area==0 throughout: done is high exactly 3*(L_new-1)+2 cycles after the game_tik cycle.
- game_tik while busy:
  - With pending==0: set pending and latch head_x, head_y and grow into the pending registers.
  - With pending==1: drop the tik and set tik_overrun, which stays set until reset or start.
- start while busy: abort immediately, clear pending and tik_overrun, go to INIT. A partial shift is discarded.
- Growth:
  - grow at snake_length==MAX_LEN keeps the length at MAX_LEN and drops the tail, the same as no grow.
  - When growing, the old tail is retained and included in the collision check.
- Arithmetic:
  - Coordinates are compared for equality only; no wrap logic lives here.
  - INIT_X must be ≥2 (checked by a parameter assertion).

Decomposition:
- Package snake_pkg: COORD_W, IDX_W, MAX_LEN, INIT_LEN=3, and the FSM state encoding (3-bit).
- Sub-module snake_seg_ram: single-port synchronous RAM, 16x14, with write enable and registered read. The address/write mux lives in the sequencer.

Test Plan:
- Init and readback: reset low 50 ns, release, pulse start with display_area=0 → done pulse, snake_length=3. Then with display_area=1, rd_idx=0,1,2 → (20,15), (19,15), (18,15).
- Plain step: game_tik with head=(21,15), grow=0, display_area=0 → done exactly 8 cycles later, length 3, body (21,15), (20,15), (19,15), self_collision=0.
- Growth: game_tik with head=(22,15), grow=1 → done 11 cycles later, length 4, seg3=(19,15).
- Render stall: raise display_area for 20 cycles mid-step → done delayed by exactly 20 cycles, final body identical to the unstalled result, and rd_x/rd_y correct throughout the stall.
- Self-collision: with body (21,15), (20,15), (19,15), game_tik head=(20,15) → self_collision=1 with done. The next non-colliding step clears it.
- Overrun and saturation: three game_tik pulses 2 cycles apart → second tik is executed after the first, third is dropped, tik_overrun=1. Twelve growth steps from length 3 → snake_length saturates at 15.
